// File: rtl/register_unit_sb.sv
// NREGS x XLEN integer register file: two async read ports with write bypass, one sync write
// port, and a single-bit-per-register pending-write scoreboard for RAW hazard detection.
module register_unit_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic                     RUWr,
  input  logic [XLEN-1:0]          RUDataWr,
  input  logic                     issue_en,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  output logic [XLEN-1:0]          RUrs1,
  output logic [XLEN-1:0]          RUrs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [NREGS-1:0]         pending
);

  localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_nxt;
  logic             wr_en;
  logic             set_en;

  // Reset masks both request paths so bypass and busy see only reset contents.
  assign wr_en  = RUWr && (rd != '0) && !rst;
  assign set_en = issue_en && (issue_rd != '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_VAL : '0;
      end
    end else if (wr_en) begin
      regs[rd] <= RUDataWr;
    end
  end

  // Set is applied after clear so a new producer on the retiring register stays outstanding.
  always_comb begin
    pend_nxt = pend_q;
    if (wr_en) begin
      pend_nxt[rd] = 1'b0;
    end
    if (set_en) begin
      pend_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  always_comb begin
    RUrs1 = regs[rs1];
    if (rs1 == '0) begin
      RUrs1 = '0;
    end else if (wr_en && (rd == rs1)) begin
      RUrs1 = RUDataWr;
    end

    RUrs2 = regs[rs2];
    if (rs2 == '0) begin
      RUrs2 = '0;
    end else if (wr_en && (rd == rs2)) begin
      RUrs2 = RUDataWr;
    end
  end

  // A retiring write releases its reader in the same cycle, matching the bypass.
  assign rs1_busy = pend_q[rs1] && !(wr_en && (rd == rs1));
  assign rs2_busy = pend_q[rs2] && !(wr_en && (rd == rs2));
  assign pending  = pend_q;

endmodule

// File: tb/tb_register_unit_sb.sv
// Bench for register_unit_sb: default 32x32 instance driven by a vector table, a reset
// sequence and a model-driven random run; a 16x64 instance exercises the wide configuration.
`timescale 1ns/100ps
module tb_register_unit_sb;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
    logic [31:0] ep;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [4:0]  rs1_a, rs2_a, rd_a, ird_a;
  logic        wr_a, iss_a;
  logic [31:0] wd_a, o1_a, o2_a, pend_a;
  logic        b1_a, b2_a;

  logic [3:0]  rs1_b, rs2_b, rd_b, ird_b;
  logic        wr_b, iss_b;
  logic [63:0] wd_b, o1_b, o2_b;
  logic [15:0] pend_b;
  logic        b1_b, b2_b;

  int errors = 0;
  int checks = 0;
  vec_t q[$];
  vec_t tbl[15];
  logic [31:0] mregs [32];
  logic [31:0] mpend;

  register_unit_sb dut_a (
    .clk(clk), .rst(rst), .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .RUWr(wr_a),
    .RUDataWr(wd_a), .issue_en(iss_a), .issue_rd(ird_a), .RUrs1(o1_a), .RUrs2(o2_a),
    .rs1_busy(b1_a), .rs2_busy(b2_a), .pending(pend_a)
  );

  register_unit_sb #(.XLEN(64), .NREGS(16), .SP_IDX(14), .SP_INIT(4096)) dut_b (
    .clk(clk), .rst(rst), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .RUWr(wr_b),
    .RUDataWr(wd_b), .issue_en(iss_b), .issue_rd(ird_b), .RUrs1(o1_b), .RUrs2(o2_b),
    .rs1_busy(b1_b), .rs2_busy(b2_b), .pending(pend_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r1, input int r2, input bit w, input int d,
                              input logic [31:0] wd, input bit is, input int ir,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input bit b1, input bit b2, input logic [31:0] ep);
    vec_t v;
    v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.wr = w; v.rd = 5'(d); v.wd = wd;
    v.iss = is; v.ird = 5'(ir); v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2; v.ep = ep;
    return v;
  endfunction

  // Drive one vector at the falling edge, check combinational outputs, then pending after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    rs1_a = v.rs1; rs2_a = v.rs2; wr_a = v.wr; rd_a = v.rd; wd_a = v.wd;
    iss_a = v.iss; ird_a = v.ird;
    q.push_back(v);
    #1;
    e = q.pop_front();
    chk({tag, ".RUrs1"}, 64'(o1_a), 64'(e.e1));
    chk({tag, ".RUrs2"}, 64'(o2_a), 64'(e.e2));
    chk({tag, ".rs1_busy"}, 64'(b1_a), 64'(e.b1));
    chk({tag, ".rs2_busy"}, 64'(b2_a), 64'(e.b2));
    @(posedge clk);
    #1;
    chk({tag, ".pending"}, 64'(pend_a), 64'(e.ep));
    @(negedge clk);
  endtask

  task automatic idle_a();
    rs1_a = '0; rs2_a = '0; rd_a = '0; ird_a = '0; wr_a = 1'b0; iss_a = 1'b0; wd_a = '0;
  endtask

  task automatic idle_b();
    rs1_b = '0; rs2_b = '0; rd_b = '0; ird_b = '0; wr_b = 1'b0; iss_b = 1'b0; wd_b = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] npend;
    bit wen;

    tbl[0]  = mk(2, 0, 0, 0, 0, 0, 0, 1000, 0, 0, 0, 32'h0);
    tbl[1]  = mk(5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[2]  = mk(5, 2, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1000, 0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h80);
    tbl[5]  = mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h80);
    tbl[6]  = mk(5, 7, 1, 7, 42, 0, 0, 32'hDEADBEEF, 42, 0, 0, 32'h0);
    tbl[7]  = mk(0, 7, 0, 0, 0, 0, 0, 0, 42, 0, 0, 32'h0);
    tbl[8]  = mk(9, 9, 0, 0, 0, 1, 9, 0, 0, 0, 0, 32'h200);
    tbl[9]  = mk(9, 3, 1, 9, 32'h99, 1, 9, 32'h99, 0, 0, 0, 32'h200);
    tbl[10] = mk(9, 3, 1, 9, 32'h77, 1, 3, 32'h77, 0, 0, 0, 32'h8);
    tbl[11] = mk(9, 3, 0, 0, 0, 0, 0, 32'h77, 0, 0, 1, 32'h8);
    tbl[12] = mk(3, 12, 1, 12, 5, 0, 0, 0, 5, 1, 0, 32'h8);
    tbl[13] = mk(3, 12, 0, 0, 0, 1, 3, 0, 5, 1, 0, 32'h8);
    tbl[14] = mk(2, 1, 1, 2, 32'hCAFE, 1, 1, 32'hCAFE, 0, 0, 0, 32'hA);

    idle_a();
    idle_b();
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset pulsed between edges; all contents visible before the next clock.
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      rs1_a = 5'(i);
      rs2_a = 5'(31 - i);
      #0.2;
      chk($sformatf("rst.reg%0d", i), 64'(o1_a), (i == 2) ? 64'd1000 : 64'd0);
    end
    chk("rst.pending", 64'(pend_a), 64'h0);
    chk("rst.busy", {62'b0, b1_a, b2_a}, 64'h0);
    idle_a();
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset mid-operation: contents, SP and pending revert with no clock edge.
    rs1_a = 5'd5; rs2_a = 5'd3;
    #2 rst = 1'b1;
    #1;
    chk("midrst.reg5", 64'(o1_a), 64'h0);
    chk("midrst.busy3", 64'(b2_a), 64'h0);
    chk("midrst.pending", 64'(pend_a), 64'h0);
    rs2_a = 5'd2;
    #1;
    chk("midrst.sp", 64'(o2_a), 64'd1000);
    wr_a = 1'b1; rd_a = 5'd5; wd_a = 32'hFFFF; iss_a = 1'b1; ird_a = 5'd6;
    #1;
    chk("midrst.nobypass", 64'(o1_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_a();
    rs1_a = 5'd5;
    #1;
    chk("midrst.wr_ignored", 64'(o1_a), 64'h0);
    chk("midrst.iss_ignored", 64'(pend_a), 64'h0);
    @(negedge clk);

    // Random traffic against a reference model of the register file and scoreboard.
    pulse_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mregs[2] = 32'd1000;
    mpend = '0;
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.rd  = 5'($urandom_range(0, 7));
      v.ird = 5'($urandom_range(0, 7));
      v.wr  = 1'($urandom_range(0, 1));
      v.iss = 1'($urandom_range(0, 1));
      v.wd  = $urandom;
      wen = v.wr && (v.rd != 0);
      v.e1 = (v.rs1 == 0) ? 32'h0 : (wen && v.rd == v.rs1) ? v.wd : mregs[v.rs1];
      v.e2 = (v.rs2 == 0) ? 32'h0 : (wen && v.rd == v.rs2) ? v.wd : mregs[v.rs2];
      v.b1 = mpend[v.rs1] && !(wen && v.rd == v.rs1);
      v.b2 = mpend[v.rs2] && !(wen && v.rd == v.rs2);
      npend = mpend;
      if (wen) npend[v.rd] = 1'b0;
      if (v.iss && v.ird != 0) npend[v.ird] = 1'b1;
      v.ep = npend;
      apply(v, $sformatf("rnd%0d", n));
      if (wen) mregs[v.rd] = v.wd;
      mpend = npend;
    end
    idle_a();

    // Wide configuration: 64-bit data, 16 registers, SP at 14.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      rs1_b = 4'(i);
      #0.2;
      chk($sformatf("w.rst.reg%0d", i), o1_b, (i == 14) ? 64'd4096 : 64'd0);
    end
    chk("w.rst.pending", 64'(pend_b), 64'h0);
    @(negedge clk);
    wr_b = 1'b1; rd_b = 4'd5; wd_b = 64'hDEADBEEF_01234567; rs1_b = 4'd5;
    #1;
    chk("w.bypass", o1_b, 64'hDEADBEEF_01234567);
    @(negedge clk);
    wr_b = 1'b0;
    #1;
    chk("w.stored", o1_b, 64'hDEADBEEF_01234567);
    iss_b = 1'b1; ird_b = 4'd7; rs2_b = 4'd7;
    #1;
    chk("w.busy_before", 64'(b2_b), 64'h0);
    @(negedge clk);
    iss_b = 1'b0;
    #1;
    chk("w.pending7", 64'(pend_b), 64'h80);
    chk("w.busy7", 64'(b2_b), 64'h1);
    wr_b = 1'b1; rd_b = 4'd7; wd_b = 64'hFFFF0000_0000002A;
    #1;
    chk("w.busy_retire", 64'(b2_b), 64'h0);
    chk("w.retire_bypass", o2_b, 64'hFFFF0000_0000002A);
    @(negedge clk);
    wr_b = 1'b1; rd_b = 4'd0; wd_b = 64'h1234; iss_b = 1'b1; ird_b = 4'd0; rs1_b = 4'd0;
    #1;
    chk("w.pending_clr", 64'(pend_b), 64'h0);
    chk("w.x0_read", o1_b, 64'h0);
    @(negedge clk);
    idle_b();
    rs2_b = 4'd7;
    #1;
    chk("w.x0_pending", 64'(pend_b), 64'h0);
    chk("w.x0_busy", 64'(b1_b), 64'h0);
    chk("w.reg7", o2_b, 64'hFFFF0000_0000002A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
